// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Each digit owns one slot of DIV clock cycles. The first BLANK_CYCLES of a
// slot keep every anode off so the previous digit's pattern cannot ghost.
// Values are captured into a pending register and only move to the displayed
// (active) register at the end of a frame, so a frame never mixes old and new data.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int SLOT_HZ      = 4_000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIV = CLK_HZ / SLOT_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;

  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_en;
  logic                    r_pend_valid;

  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_en;

  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_slot_wrap;
  logic                    w_frame_end;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic [NUM_DIGITS-1:0]   w_visible;
  logic                    w_vis_cur;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg_next;
  logic                    w_dp_next;
  logic [NUM_DIGITS-1:0]   w_an_next;

  // Active-low hex patterns, bit 6 = segment a down to bit 0 = segment g.
  function automatic logic [6:0] decodeHex(input logic [3:0] nib);
    case (nib)
      4'h0:    decodeHex = 7'b0000001;
      4'h1:    decodeHex = 7'b1001111;
      4'h2:    decodeHex = 7'b0010010;
      4'h3:    decodeHex = 7'b0000110;
      4'h4:    decodeHex = 7'b1001100;
      4'h5:    decodeHex = 7'b0100100;
      4'h6:    decodeHex = 7'b0100000;
      4'h7:    decodeHex = 7'b0001111;
      4'h8:    decodeHex = 7'b0000000;
      4'h9:    decodeHex = 7'b0000100;
      4'hA:    decodeHex = 7'b0001000;
      4'hB:    decodeHex = 7'b1100000;
      4'hC:    decodeHex = 7'b0110001;
      4'hD:    decodeHex = 7'b1000010;
      4'hE:    decodeHex = 7'b0110000;
      default: decodeHex = 7'b0111000;
    endcase
  endfunction

  assign w_slot_wrap = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_wrap && (r_idx == IDX_LAST);
  assign w_nib       = r_act_val[{r_idx, 2'b00} +: 4];
  assign w_visible   = r_act_en & ~w_lz_blank;
  assign w_vis_cur   = w_visible[r_idx];

  // Walk from the top digit down; a digit is a leading zero while it and all above read as zero.
  always_comb begin
    logic w_zero_run;
    w_zero_run = 1'b1;
    w_lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (~r_act_en[k] | (r_act_val[4*k +: 4] == 4'h0));
      if (k != 0) begin
        w_lz_blank[k] = w_zero_run & blank_lz;
      end
    end
  end

  // Output pattern for the current slot position; anode held off during the ghost guard.
  always_comb begin
    w_seg_next = 7'b1111111;
    w_dp_next  = 1'b1;
    w_an_next  = '1;
    if (w_vis_cur) begin
      w_seg_next = decodeHex(w_nib);
      w_dp_next  = ~r_act_dp[r_idx];
      if (r_cnt >= CNT_BLANK) begin
        w_an_next[r_idx] = 1'b0;
      end
    end
  end

  // Slot counter and digit index; the index advances each time the slot counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_wrap) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pending/active double buffer; transfer at frame end happens before a same-cycle load lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_en    <= '0;
      r_pend_valid <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_act_en     <= '0;
    end else begin
      if (w_frame_end && r_pend_valid) begin
        r_act_val    <= r_pend_val;
        r_act_dp     <= r_pend_dp;
        r_act_en     <= r_pend_en;
        r_pend_valid <= 1'b0;
      end
      if (load) begin
        r_pend_val   <= value;
        r_pend_dp    <= dp_in;
        r_pend_en    <= digit_en;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Register every display output so the pins are glitch-free, one cycle behind the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_next;
      r_dp         <= w_dp_next;
      r_an         <= w_an_next;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with a 10-cycle slot and 2-cycle ghost guard.
// A behavioural display model predicts every output cycle through a scoreboard queue.
module tb_seven_seg_scanner;

  localparam int ND   = 4;
  localparam int DIV  = 10;
  localparam int BLK  = 2;
  localparam int FRM  = ND * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int t;
  int lastFd;

  logic [15:0] mPendVal, mActVal;
  logic [3:0]  mPendDp, mActDp, mPendEn, mActEn;
  logic        mPendValid;

  exp_t sb[$];

  logic [6:0] segTable [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seven_seg_scanner #(
    .NUM_DIGITS  (ND),
    .CLK_HZ      (1000),
    .SLOT_HZ     (100),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .blank_lz  (blank_lz),
    .load      (load),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

  // Expected pins for slot-tick tt, from the model's active data and the live blank_lz.
  function automatic exp_t predict(input int tt);
    int   idx = (tt / DIV) % ND;
    int   c   = tt % DIV;
    logic vis;
    logic allZero;
    exp_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.fd  = (idx == ND - 1) && (c == DIV - 1);
    vis = mActEn[idx];
    if (blank_lz && idx > 0) begin
      allZero = 1'b1;
      for (int j = idx; j < ND; j++) begin
        if (mActEn[j] && mActVal[j*4 +: 4] != 4'h0) allZero = 1'b0;
      end
      if (allZero) vis = 1'b0;
    end
    if (vis) begin
      e.seg = segTable[mActVal[idx*4 +: 4]];
      e.dp  = ~mActDp[idx];
      if (c >= BLK) e.an[idx] = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput(tag, {3'b0, an, seg, dp, frame_done}, {3'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
  endtask

  task automatic resetModel();
    t          = 0;
    lastFd     = -1;
    mPendVal   = '0;
    mPendDp    = '0;
    mPendEn    = '0;
    mPendValid = 1'b0;
    mActVal    = '0;
    mActDp     = '0;
    mActEn     = '0;
  endtask

  // One clock of stimulus: queue the prediction, advance the model, then compare on the falling edge.
  task automatic applyStimulus();
    exp_t e;
    exp_t got;
    int   c   = t % DIV;
    int   idx = (t / DIV) % ND;
    sb.push_back(predict(t));
    if (idx == ND - 1 && c == DIV - 1 && mPendValid) begin
      mActVal    = mPendVal;
      mActDp     = mPendDp;
      mActEn     = mPendEn;
      mPendValid = 1'b0;
    end
    if (load) begin
      mPendVal   = value;
      mPendDp    = dp_in;
      mPendEn    = digit_en;
      mPendValid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    e   = sb.pop_front();
    got = '{an: an, seg: seg, dp: dp, fd: frame_done};
    checkOutput($sformatf("scan_t%0d", t), {3'b0, got}, {3'b0, e});
    if (frame_done === 1'b1) begin
      if (lastFd >= 0) checkOutput("fd_period", 16'(t - lastFd), 16'(FRM));
      lastFd = t;
    end
    t++;
  endtask

  task automatic runTo(input int n);
    while (t < n) applyStimulus();
  endtask

  task automatic loadValues(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dps);
    value    = v;
    digit_en = en;
    dp_in    = dps;
    load     = 1'b1;
    applyStimulus();
    load     = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    value    = '0;
    dp_in    = '0;
    digit_en = '0;
    blank_lz = 1'b0;
    load     = 1'b0;
    resetModel();

    // Reset held for five cycles, with a load attempt that must be ignored.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        value    = 16'hFFFF;
        digit_en = 4'hF;
        load     = 1'b1;
      end
      checkReset($sformatf("reset_hold%0d", i));
    end
    load  = 1'b0;
    rst_n = 1'b1;

    // Decode of 1234: blank first frame, shown from the second frame on.
    loadValues(16'h1234, 4'hF, 4'h0);
    runTo(42);
    checkOutput("guard_an", 16'(an), 16'(4'b1111));
    runTo(43);
    checkOutput("d0_an", 16'(an), 16'(4'b1110));
    checkOutput("d0_seg4", 16'(seg), 16'(7'b1001100));
    runTo(73);
    checkOutput("d3_an", 16'(an), 16'(4'b0111));
    checkOutput("d3_seg1", 16'(seg), 16'(7'b1001111));
    runTo(120);

    // Leading-zero blanking of 0050, then of 0000.
    blank_lz = 1'b1;
    runTo(125);
    loadValues(16'h0050, 4'hF, 4'h0);
    runTo(173);
    checkOutput("lz_d1_an", 16'(an), 16'(4'b1101));
    checkOutput("lz_d1_seg5", 16'(seg), 16'(7'b0100100));
    runTo(200);
    loadValues(16'h0000, 4'hF, 4'h0);
    runTo(283);
    checkOutput("lz_d0_an", 16'(an), 16'(4'b1110));
    checkOutput("lz_d0_seg0", 16'(seg), 16'(7'b0000001));
    runTo(320);

    // Tear-free update: AAAA mid-frame, BBBB on the frame-end cycle.
    blank_lz = 1'b0;
    runTo(335);
    loadValues(16'hAAAA, 4'hF, 4'h0);
    runTo(359);
    loadValues(16'hBBBB, 4'hF, 4'h0);
    runTo(393);
    checkOutput("tear_A_seg", 16'(seg), 16'(7'b0001111 ^ 7'b0000111));
    runTo(433);
    checkOutput("tear_B_seg", 16'(seg), 16'(7'b1100000));
    runTo(440);

    // Per-digit enable and decimal point.
    loadValues(16'h89AB, 4'b0101, 4'b0001);
    runTo(483);
    checkOutput("en_d0_an", 16'(an), 16'(4'b1110));
    checkOutput("en_d0_dp", 16'(dp), 16'(1'b0));
    runTo(503);
    checkOutput("en_d2_an", 16'(an), 16'(4'b1011));
    checkOutput("en_d2_dp", 16'(dp), 16'(1'b1));
    runTo(545);

    // Asynchronous reset in the middle of digit 2's slot.
    checkOutput("pre_reset_an", 16'(an), 16'(4'b1011));
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkReset($sformatf("mid_reset_hold%0d", i));
    end
    rst_n = 1'b1;
    resetModel();
    runTo(40);
    loadValues(16'h000C, 4'hF, 4'h0);
    runTo(83);
    checkOutput("restart_d0_an", 16'(an), 16'(4'b1110));
    checkOutput("restart_d0_segC", 16'(seg), 16'(7'b0110001));
    runTo(160);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
